corr_path_scheduler: RTL

//  Sequences the Correlator for Monte Carlo runs of the Heston engine.

---
 rtl/corr_path_scheduler_if.sv | 28 ++
 rtl/corr_path_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_path_scheduler_if.sv
// Stream bundle between the scheduler and its environment: Gaussian pairs in, tagged W results out.
interface corr_path_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             g_valid;
  logic             g_ready;
  logic [22:0]      g1;
  logic [22:0]      g2;
  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w1;
  logic [31:0]      w2;
  logic [CNT_W-1:0] w_step;
  logic [CNT_W-1:0] w_path;
  logic             w_last;

  // Environment side: supplies Gaussian pairs, consumes results.
  modport master (
    output g_valid, g1, g2, w_ready,
    input  g_ready, w_valid, w1, w2, w_step, w_path, w_last
  );

  // Scheduler side.
  modport slave (
    input  g_valid, g1, g2, w_ready,
    output g_ready, w_valid, w1, w2, w_step, w_path, w_last
  );
endinterface

// File: rtl/corr_path_scheduler.sv
// Sequences the Correlator for Heston Monte Carlo runs: flush, metered issue with
// step/path tags, and a credit-protected output FIFO so results are never dropped.
module corr_path_scheduler #(
  parameter int unsigned CORR_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RST_CYC    = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [CNT_W-1:0] num_paths,
  input  logic [31:0]      cfg_rho,
  input  logic [31:0]      cfg_sqrt,
  output logic             busy,
  output logic             done,
  output logic             corr_rst,
  output logic [22:0]      corr_g1,
  output logic [22:0]      corr_g2,
  output logic [31:0]      corr_rho,
  output logic [31:0]      corr_sqrt,
  input  logic [31:0]      corr_w1,
  input  logic [31:0]      corr_w2,
  corr_path_scheduler_if.slave s
);

  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + CORR_LAT + 2) + 1;
  localparam int unsigned FCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  // Stage 0 rides alongside corr_g1/g2; the next CORR_LAT stages track the Correlator pipeline.
  localparam int unsigned NT  = CORR_LAT + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_RUN, ST_DRAIN} state_t;

  typedef struct packed {
    logic             v;
    logic             last;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] path;
  } tag_t;

  typedef struct packed {
    logic [31:0]      w1;
    logic [31:0]      w2;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] path;
    logic             last;
  } entry_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d, paths_q, paths_d;
  logic [CNT_W-1:0] step_q, step_d, path_q, path_d;
  logic [31:0]      rho_lat_q, rho_lat_d, sqrt_lat_q, sqrt_lat_d;
  logic [31:0]      corr_rho_q, corr_rho_d, corr_sqrt_q, corr_sqrt_d;
  logic [22:0]      corr_g1_q, corr_g1_d, corr_g2_q, corr_g2_d;
  logic [FCW-1:0]   flush_q, flush_d;
  logic             busy_q, busy_d, done_q, done_d, corr_rst_q, corr_rst_d;
  tag_t             tag_q [NT];
  tag_t             tag_d [NT];
  entry_t           mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CW-1:0]    inflight;
  logic [CW-1:0]    occ_after_pop;
  logic             g_ready_c, hs, pop, push, last_idx, drained;
  entry_t           head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit accounting: valid tags in flight plus FIFO occupancy after any pop this cycle.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      inflight = inflight + CW'(tag_q[i].v);
    end
    pop           = (count_q != '0) && s.w_ready;
    push          = tag_q[NT-1].v;
    occ_after_pop = inflight + count_q - CW'(pop);
    g_ready_c     = (state_q == ST_RUN) && (occ_after_pop < CW'(FIFO_DEPTH));
    hs            = s.g_valid && g_ready_c;
    last_idx      = (step_q == steps_q - CNT_W'(1)) && (path_q == paths_q - CNT_W'(1));
    drained       = (inflight == '0) &&
                    ((count_q == '0) || ((count_q == CW'(1)) && pop));
  end

  // Next-state, counters, tag pipe and FIFO pointers.
  always_comb begin
    state_d     = state_q;
    steps_d     = steps_q;
    paths_d     = paths_q;
    step_d      = step_q;
    path_d      = path_q;
    rho_lat_d   = rho_lat_q;
    sqrt_lat_d  = sqrt_lat_q;
    corr_rho_d  = rho_lat_q;
    corr_sqrt_d = sqrt_lat_q;
    corr_g1_d   = corr_g1_q;
    corr_g2_d   = corr_g2_q;
    flush_d     = flush_q;
    done_d      = 1'b0;
    tag_d[0]    = '0;
    for (int unsigned i = 1; i < NT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          steps_d    = num_steps;
          paths_d    = num_paths;
          rho_lat_d  = cfg_rho;
          sqrt_lat_d = cfg_sqrt;
          if ((num_steps == '0) || (num_paths == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FLUSH;
            flush_d = '0;
            step_d  = '0;
            path_d  = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FCW'(RST_CYC - 1)) begin
          state_d = ST_RUN;
        end else begin
          flush_d = flush_q + FCW'(1);
        end
      end
      ST_RUN: begin
        if (hs) begin
          corr_g1_d = s.g1;
          corr_g2_d = s.g2;
          tag_d[0]  = '{v: 1'b1, last: last_idx, step: step_q, path: path_q};
          if (last_idx) begin
            step_d  = '0;
            path_d  = '0;
            state_d = ST_DRAIN;
          end else if (step_q == steps_q - CNT_W'(1)) begin
            step_d = '0;
            path_d = path_q + CNT_W'(1);
          end else begin
            step_d = step_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    corr_rst_d = (state_d == ST_FLUSH);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  // State and control registers; reset aborts any run silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      steps_q     <= '0;
      paths_q     <= '0;
      step_q      <= '0;
      path_q      <= '0;
      rho_lat_q   <= '0;
      sqrt_lat_q  <= '0;
      corr_rho_q  <= '0;
      corr_sqrt_q <= '0;
      corr_g1_q   <= '0;
      corr_g2_q   <= '0;
      flush_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      corr_rst_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < NT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      steps_q     <= steps_d;
      paths_q     <= paths_d;
      step_q      <= step_d;
      path_q      <= path_d;
      rho_lat_q   <= rho_lat_d;
      sqrt_lat_q  <= sqrt_lat_d;
      corr_rho_q  <= corr_rho_d;
      corr_sqrt_q <= corr_sqrt_d;
      corr_g1_q   <= corr_g1_d;
      corr_g2_q   <= corr_g2_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      corr_rst_q  <= corr_rst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int unsigned i = 0; i < NT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // FIFO storage: Correlator output joined with its tag as the tag leaves the pipe.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{w1: corr_w1, w2: corr_w2, step: tag_q[NT-1].step,
                           path: tag_q[NT-1].path, last: tag_q[NT-1].last};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign s.g_ready = g_ready_c;
  assign s.w_valid = (count_q != '0);
  assign s.w1      = head.w1;
  assign s.w2      = head.w2;
  assign s.w_step  = head.step;
  assign s.w_path  = head.path;
  assign s.w_last  = head.last;

  assign busy      = busy_q;
  assign done      = done_q;
  assign corr_rst  = corr_rst_q;
  assign corr_g1   = corr_g1_q;
  assign corr_g2   = corr_g2_q;
  assign corr_rho  = corr_rho_q;
  assign corr_sqrt = corr_sqrt_q;

endmodule
